filter_row: RTL and testbench

- Streaming PNG scanline filter engine. Successor to the single-byte Paeth predictor.
- Covers all five PNG filter types (None/Sub/Up/Average/Paeth) and a parametrised bytes-per-pixel count.
- Keeps an internal previous-row line buffer, so the block builds its own a/b/c neighbours.
- Sits between the pixel unpacker and the deflate front end. Per row it emits the filter-type byte, then the filtered bytes.

---
 rtl/filter_row.sv | 260 ++++++++++++++++++++++++++
 tb/tb_filter_row.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_row.sv
// -----------------------------------------------------------------------------
// filter_row
//   Streaming PNG scanline filter engine. For every row it emits the
//   filter-type byte followed by the filtered bytes. It handles all five PNG
//   filter types (None/Sub/Up/Average/Paeth). An internal previous-row line
//   buffer supplies the b/c neighbours, and BPP-deep shift registers supply a
//   and c.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset; aborts any row in progress
//   start_i  row start pulse, honoured only while idle
//   type_i   filter type for the row (0 None .. 4 Paeth, 5..7 treated as 0)
//   first_i  row is the first of the image (previous row reads as zero)
//   len_i    row length in bytes (0 treated as ROW_MAX)
//   busy_o   high from start acceptance until the row completes
//   dat_i    raw input byte, qualified by val_i, accepted when rdy_o
//   val_i    dat_i valid
//   rdy_o    block accepts dat_i this cycle
//   dat_o    type byte, then filtered bytes; qualified by val_o
//   val_o    dat_o valid
//   rdy_i    downstream accepts dat_o
//   last_o   marks the final filtered byte of a row (with val_o)
//   done_o   one-cycle pulse after the final byte has been taken
// -----------------------------------------------------------------------------
module filter_row #(
    parameter int DATA_WD = 8,
    parameter int BPP     = 3,
    parameter int ROW_MAX = 1024,
    parameter int ROW_WD  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         type_i,
    input  logic               first_i,
    input  logic [ROW_WD-1:0]  len_i,
    output logic               busy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               val_i,
    output logic               rdy_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic               val_o,
    input  logic               rdy_i,
    output logic               last_o,
    output logic               done_o
);

    localparam int AW = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
    // Paeth distances need two extra bits: a+b-2c spans -510..510 for 8-bit data.
    localparam int PW = DATA_WD + 2;
    localparam logic [PW-1:0] PONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          type_q, type_d;
    logic                first_q, first_d;
    logic [ROW_WD-1:0]   len_q, len_d;
    logic [ROW_WD-1:0]   idx_q, idx_d;
    logic [DATA_WD-1:0]  dat_q, dat_d;
    logic                val_q, val_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                hist_clr;

    logic                in_fire;
    logic                out_fire;

    // ------------------------------------------------------------------
    // Previous-row line buffer. It is read asynchronously at the current
    // index, so b is available in the same cycle that x is written over it.
    // ------------------------------------------------------------------
    logic [DATA_WD-1:0]  line_mem [ROW_MAX];
    logic [AW-1:0]       mem_addr;
    logic [DATA_WD-1:0]  b_raw;

    assign mem_addr = idx_q[AW-1:0];
    assign b_raw    = line_mem[mem_addr];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            line_mem[mem_addr] <= dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Neighbours. The histories are cleared at row start, so a and c read
    // zero for the first BPP bytes. The c history is fed from the masked b,
    // so it also reads zero on a first row.
    // ------------------------------------------------------------------
    logic [DATA_WD-1:0]  a_hist_q [BPP];
    logic [DATA_WD-1:0]  c_hist_q [BPP];
    logic [DATA_WD-1:0]  a_val, b_val, c_val;

    assign a_val = a_hist_q[BPP-1];
    assign b_val = first_q ? '0 : b_raw;
    assign c_val = c_hist_q[BPP-1];

    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            for (int i = 0; i < BPP; i++) begin
                a_hist_q[i] <= '0;
                c_hist_q[i] <= '0;
            end
        end else if (in_fire) begin
            a_hist_q[0] <= dat_i;
            c_hist_q[0] <= b_val;
            for (int i = 1; i < BPP; i++) begin
                a_hist_q[i] <= a_hist_q[i-1];
                c_hist_q[i] <= c_hist_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Filter datapath
    // ------------------------------------------------------------------
    logic [DATA_WD:0]    avg_sum;
    logic [PW-1:0]       d_pa, d_pb, d_pc;
    logic [PW-1:0]       pa, pb, pc;
    logic [DATA_WD-1:0]  pred;
    logic [DATA_WD-1:0]  filt;

    assign avg_sum = {1'b0, a_val} + {1'b0, b_val};

    assign d_pa = {2'b00, b_val} - {2'b00, c_val};
    assign d_pb = {2'b00, a_val} - {2'b00, c_val};
    assign d_pc = {2'b00, a_val} + {2'b00, b_val} - {1'b0, c_val, 1'b0};

    // Two's-complement magnitude; the top bit is the sign of the difference.
    assign pa = d_pa[PW-1] ? (~d_pa + PONE) : d_pa;
    assign pb = d_pb[PW-1] ? (~d_pb + PONE) : d_pb;
    assign pc = d_pc[PW-1] ? (~d_pc + PONE) : d_pc;

    always_comb begin
        pred = c_val;
        if ((pa <= pb) && (pa <= pc)) begin
            pred = a_val;
        end else if (pb <= pc) begin
            pred = b_val;
        end
    end

    always_comb begin
        filt = dat_i;
        case (type_q)
            3'd1:    filt = dat_i - a_val;
            3'd2:    filt = dat_i - b_val;
            3'd3:    filt = dat_i - avg_sum[DATA_WD:1];
            3'd4:    filt = dat_i - pred;
            default: filt = dat_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes. The extra idx != len term stops a byte beyond the row end
    // from being accepted while the last byte is still waiting downstream.
    // ------------------------------------------------------------------
    assign rdy_o    = (state_q == S_DATA) && (!val_q || rdy_i) && (idx_q != len_q);
    assign in_fire  = rdy_o && val_i;
    assign out_fire = val_q && rdy_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        first_d  = first_q;
        len_d    = len_q;
        idx_d    = idx_q;
        dat_d    = dat_q;
        val_d    = val_q;
        last_d   = last_q;
        done_d   = 1'b0;
        hist_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start in the same cycle as done_o is not honoured.
                if (start_i && !done_q) begin
                    type_d   = (type_i > 3'd4) ? 3'd0 : type_i;
                    first_d  = first_i;
                    len_d    = (len_i == '0) ? ROW_WD'(ROW_MAX) : len_i;
                    idx_d    = '0;
                    hist_clr = 1'b1;
                    state_d  = S_HEAD;
                end
            end

            S_HEAD: begin
                if (!val_q) begin
                    dat_d  = DATA_WD'(type_q);
                    val_d  = 1'b1;
                    last_d = 1'b0;
                end else if (rdy_i) begin
                    val_d   = 1'b0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (out_fire) begin
                    val_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (in_fire) begin
                    dat_d  = filt;
                    val_d  = 1'b1;
                    last_d = (idx_q == (len_q - ROW_WD'(1)));
                    idx_d  = idx_q + ROW_WD'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            first_q <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            first_q <= first_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign dat_o  = dat_q;
    assign val_o  = val_q;
    assign last_o = last_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_filter_row.sv
// -----------------------------------------------------------------------------
// tb_filter_row
//   Scoreboard bench for filter_row. Two instances are used: inst0 has BPP=1
//   and inst1 has BPP=3. The drivers push the expected response from a
//   behavioural PNG filter model. A separate monitor pops and compares on
//   every output handshake. The monitor also checks that outputs hold while
//   stalled and that done_o timing is correct.
// -----------------------------------------------------------------------------
module tb_filter_row;

    localparam int DW   = 8;
    localparam int RW   = 11;
    localparam int RMAX = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           start_s [2];
    logic [2:0]     type_s  [2];
    logic           first_s [2];
    logic [RW-1:0]  len_s   [2];
    logic [DW-1:0]  din_s   [2];
    logic           vin_s   [2];
    logic           rdyo_s  [2];
    logic           busy_s  [2];
    logic [DW-1:0]  dout_s  [2];
    logic           vout_s  [2];
    logic           rdyi_s  [2];
    logic           last_s  [2];
    logic           done_s  [2];

    filter_row #(.DATA_WD(DW), .BPP(1), .ROW_MAX(RMAX), .ROW_WD(RW)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .start_i(start_s[0]), .type_i(type_s[0]), .first_i(first_s[0]), .len_i(len_s[0]),
        .busy_o(busy_s[0]), .dat_i(din_s[0]), .val_i(vin_s[0]), .rdy_o(rdyo_s[0]),
        .dat_o(dout_s[0]), .val_o(vout_s[0]), .rdy_i(rdyi_s[0]),
        .last_o(last_s[0]), .done_o(done_s[0])
    );

    filter_row #(.DATA_WD(DW), .BPP(3), .ROW_MAX(RMAX), .ROW_WD(RW)) u_dut_b3 (
        .clk(clk), .rst(rst),
        .start_i(start_s[1]), .type_i(type_s[1]), .first_i(first_s[1]), .len_i(len_s[1]),
        .busy_o(busy_s[1]), .dat_i(din_s[1]), .val_i(vin_s[1]), .rdy_o(rdyo_s[1]),
        .dat_o(dout_s[1]), .val_o(vout_s[1]), .rdy_i(rdyi_s[1]),
        .last_o(last_s[1]), .done_o(done_s[1])
    );

    int errors = 0;
    int checks = 0;

    int exp_q [2][$];          // expected output: data | (last << 8)
    int prev_row [2][RMAX];    // model of each instance's previous row
    int raw [RMAX];            // raw bytes of the row being driven
    int bpp_of [2] = '{1, 3};
    int stall_pct [2] = '{30, 30};
    int done_cnt [2] = '{0, 0};
    int last_take_cyc [2] = '{0, 0};
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural model (PNG filter definitions) -----------
    function automatic int model_byte(input int k, input int typ, input bit first, input int i);
        int x, a, b, c, p, pa, pb, pc, pr, r;
        x = raw[i];
        a = (i >= bpp_of[k]) ? raw[i - bpp_of[k]] : 0;
        b = first ? 0 : prev_row[k][i];
        c = (i >= bpp_of[k] && !first) ? prev_row[k][i - bpp_of[k]] : 0;
        case (typ)
            1: r = x - a;
            2: r = x - b;
            3: r = x - ((a + b) / 2);
            4: begin
                p  = a + b - c;
                pa = (p > a) ? p - a : a - p;
                pb = (p > b) ? p - b : b - p;
                pc = (p > c) ? p - c : c - p;
                if (pa <= pb && pa <= pc) pr = a;
                else if (pb <= pc)        pr = b;
                else                      pr = c;
                r = x - pr;
            end
            default: r = x;
        endcase
        return r & 255;
    endfunction

    // ---------------- rdy_i randomisation ----------------------------------
    initial begin
        rdyi_s[0] = 1'b0;
        rdyi_s[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                rdyi_s[k] = ($urandom_range(99) >= stall_pct[k]);
            end
        end
    end

    // ---------------- monitor / scoreboard ---------------------------------
    bit            stall_prev [2] = '{0, 0};
    logic [DW-1:0] held_dat   [2];
    logic          held_last  [2];

    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev[0] = 1'b0;
            stall_prev[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stall_prev[k]) begin
                    checks++;
                    if (!vout_s[k] || dout_s[k] !== held_dat[k] || last_s[k] !== held_last[k]) begin
                        errors++;
                        $display("FAIL stall_hold inst%0d: got val=%0b dat=%0d last=%0b, required val=1 dat=%0d last=%0b",
                                 k, vout_s[k], dout_s[k], last_s[k], held_dat[k], held_last[k]);
                    end
                end
                if (done_s[k]) begin
                    done_cnt[k]++;
                    checks++;
                    if (cyc != last_take_cyc[k] + 1) begin
                        errors++;
                        $display("FAIL done_timing inst%0d: done at cycle %0d, required cycle %0d",
                                 k, cyc, last_take_cyc[k] + 1);
                    end
                end
                if (vout_s[k] && rdyi_s[k]) begin
                    int got, e;
                    got = int'(dout_s[k]) + (last_s[k] ? 256 : 0);
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL extra_output inst%0d: got %0d, required nothing", k, got);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (got != e) begin
                            errors++;
                            $display("FAIL out_byte inst%0d: got dat=%0d last=%0d, required dat=%0d last=%0d",
                                     k, got & 255, got >> 8, e & 255, e >> 8);
                        end
                    end
                    if (last_s[k]) last_take_cyc[k] = cyc;
                end
                stall_prev[k] = vout_s[k] && !rdyi_s[k];
                held_dat[k]   = dout_s[k];
                held_last[k]  = last_s[k];
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check_idle_outputs(input int k, input string tag);
        bit [5:0] got;
        got = {busy_s[k], rdyo_s[k], vout_s[k], last_s[k], done_s[k], (dout_s[k] != '0)};
        checks++;
        if (got != 6'b0) begin
            errors++;
            $display("FAIL %s inst%0d: got busy,rdy,val,last,done,dat!=0 = %b, required 000000", tag, k, got);
        end
    endtask

    // Drives one row. If abort_at > 0 the row is cut short by a reset after
    // abort_at bytes have been accepted.
    task automatic run_row(input int k, input int typ, input bit first, input int len,
                           input bit poke, input int abort_at);
        int eff, i, to, d0;
        eff = (typ > 4) ? 0 : typ;
        exp_q[k].push_back(eff);
        for (int j = 0; j < len; j++) begin
            exp_q[k].push_back(model_byte(k, eff, first, j) + ((j == len - 1) ? 256 : 0));
        end
        d0 = done_cnt[k];

        @(posedge clk);
        #1;
        start_s[k] = 1'b1;
        type_s[k]  = 3'(typ);
        first_s[k] = first;
        len_s[k]   = RW'(len);
        @(posedge clk);
        #1;
        start_s[k] = 1'b0;

        i  = 0;
        to = 0;
        while (i < len && to < 20000 && !(abort_at > 0 && i >= abort_at)) begin
            if ($urandom_range(3) == 0) begin
                vin_s[k] = 1'b0;
            end else begin
                vin_s[k] = 1'b1;
                din_s[k] = 8'(raw[i]);
            end
            // A start pulse mid-row must be ignored.
            start_s[k] = poke && (i == 2);
            type_s[k]  = poke ? 3'd0 : 3'(typ);
            @(negedge clk);
            begin
                bit took;
                took = vin_s[k] && rdyo_s[k];
                @(posedge clk);
                #1;
                if (took) i++;
            end
            to++;
        end
        vin_s[k]   = 1'b0;
        start_s[k] = 1'b0;

        if (abort_at > 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q[k].delete();
            for (int j = 0; j < i; j++) prev_row[k][j] = raw[j];
            check_idle_outputs(k, "abort_reset");
            repeat (10) @(posedge clk);
            checks++;
            if (done_cnt[k] != d0) begin
                errors++;
                $display("FAIL abort_no_done inst%0d: got %0d done pulses, required 0", k, done_cnt[k] - d0);
            end
            $display("row inst%0d type=%0d len=%0d aborted after %0d bytes", k, typ, len, i);
            return;
        end

        if (i < len) begin
            errors++;
            $display("FAIL input_timeout inst%0d: accepted %0d bytes, required %0d", k, i, len);
        end
        to = 0;
        while (done_cnt[k] == d0 && to < 500) begin
            @(posedge clk);
            to++;
        end
        checks++;
        if (done_cnt[k] == d0) begin
            errors++;
            $display("FAIL done_timeout inst%0d: got no done_o, required one", k);
        end
        for (int j = 0; j < len; j++) prev_row[k][j] = raw[j];
        $display("row inst%0d type=%0d first=%0b len=%0d complete", k, typ, first, len);
    endtask

    task automatic set_raw3(input int v0, input int v1, input int v2);
        raw[0] = v0; raw[1] = v1; raw[2] = v2;
    endtask

    task automatic fill_random(input int len);
        for (int j = 0; j < len; j++) raw[j] = int'($urandom_range(255));
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; type_s[k] = '0; first_s[k] = 1'b0;
            len_s[k] = '0; din_s[k] = '0; vin_s[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset_state");
        check_idle_outputs(1, "reset_state");
        rst = 1'b0;

        // BPP=1 Sub on a first row: 5,10,20 -> 1,5,5,10
        set_raw3(5, 10, 20);
        run_row(0, 1, 1'b1, 3, 1'b0, 0);

        // Up: row0 10,20,30 ; row1 15,18,40 -> 2,5,254,10
        set_raw3(10, 20, 30);
        run_row(0, 0, 1'b1, 3, 1'b0, 0);
        set_raw3(15, 18, 40);
        run_row(0, 2, 1'b0, 3, 1'b0, 0);

        // Paeth: row0 20,15 ; row1 10,100 -> 4,246,90
        raw[0] = 20; raw[1] = 15;
        run_row(0, 0, 1'b1, 2, 1'b0, 0);
        raw[0] = 10; raw[1] = 100;
        run_row(0, 4, 1'b0, 2, 1'b0, 0);

        // Paeth tie: row0 15,20 ; row1 10,100 -> second byte predicts c=15 -> 85
        raw[0] = 15; raw[1] = 20;
        run_row(0, 0, 1'b1, 2, 1'b0, 0);
        raw[0] = 10; raw[1] = 100;
        run_row(0, 4, 1'b0, 2, 1'b0, 0);

        // BPP=3 Average: row0 0,0,0,21,21,21 ; row1 1,2,3,50,50,50 -> 3,1,2,3,39,39,38
        raw[0] = 0; raw[1] = 0; raw[2] = 0; raw[3] = 21; raw[4] = 21; raw[5] = 21;
        run_row(1, 0, 1'b1, 6, 1'b0, 0);
        raw[0] = 1; raw[1] = 2; raw[2] = 3; raw[3] = 50; raw[4] = 50; raw[5] = 50;
        run_row(1, 3, 1'b0, 6, 1'b0, 0);

        // BPP=3 random rows of varying length and type (5..7 included)
        for (int r = 0; r < 8; r++) begin
            int len;
            len = int'($urandom_range(1, 40));
            fill_random(len);
            run_row(1, int'($urandom_range(0, 7)), (r == 0), len, 1'b0, 0);
        end

        // Full-length Paeth row under heavy downstream stalls, with a mid-row start
        stall_pct[0] = 50;
        fill_random(RMAX);
        run_row(0, 0, 1'b1, RMAX, 1'b0, 0);
        fill_random(RMAX);
        run_row(0, 4, 1'b0, RMAX, 1'b1, 0);
        stall_pct[0] = 30;

        // Reset mid-row, then a clean first row (type 5 behaves as None), then len 1
        fill_random(20);
        run_row(0, 4, 1'b0, 20, 1'b0, 7);
        fill_random(4);
        run_row(0, 5, 1'b1, 4, 1'b0, 0);
        raw[0] = 200;
        run_row(0, 2, 1'b0, 1, 1'b0, 0);

        repeat (5) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL leftover_expected inst%0d: got %0d outputs missing, required 0", k, exp_q[k].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
